// File: rtl/nes_cpu_bus_responder_if.sv
// CPU-side data/address bus between the 6502 core and the bus responder.
// The CPU drives the address/control; the responder returns registered read data.
interface nes_cpu_bus_responder_if;
  logic [15:0] addr;
  logic        rw;
  logic [7:0]  wdata;
  logic [7:0]  rdata;

  modport master (output addr, output rw, output wdata, input rdata);
  modport slave  (input addr, input rw, input wdata, output rdata);
endinterface

// File: rtl/nes_cpu_bus_responder.sv
// CPU bus slave: mirrored work RAM, $4016/$4017 controller ports, PRG-ROM
// forwarding and open-bus hold of the last read value.
module nes_cpu_bus_responder #(
  parameter int RAM_AW   = 11,
  parameter int PAD_BITS = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  nes_cpu_bus_responder_if.slave bus,
  output logic [14:0]           prg_addr,
  input  logic [7:0]            prg_data,
  input  logic [PAD_BITS-1:0]   pad1_buttons,
  input  logic [PAD_BITS-1:0]   pad2_buttons
);

  localparam int            CW      = $clog2(PAD_BITS + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(PAD_BITS);

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] c);
    return (c == CNT_MAX) ? c : c + CW'(1);
  endfunction

  logic [7:0]          ram_q [2**RAM_AW];
  logic [RAM_AW-1:0]   ram_idx_s;
  logic [7:0]          ram_rd_s;
  logic                sel_ram_s, sel_pad1_s, sel_pad2_s, sel_prg_s;
  logic                pad1_bit_s, pad2_bit_s;

  logic [7:0]          rdata_q, rdata_d;
  logic                strobe_q, strobe_d;
  logic [PAD_BITS-1:0] sr1_q, sr1_d, sr2_q, sr2_d;
  logic [CW-1:0]       cnt1_q, cnt1_d, cnt2_q, cnt2_d;

  assign prg_addr  = bus.addr[14:0];
  assign bus.rdata = rdata_q;
  assign ram_idx_s = bus.addr[RAM_AW-1:0];
  assign ram_rd_s  = ram_q[ram_idx_s];

  // Address decode and the bit each controller port would present this cycle
  always_comb begin
    sel_ram_s  = (bus.addr[15:13] == 3'b000);
    sel_pad1_s = (bus.addr == 16'h4016);
    sel_pad2_s = (bus.addr == 16'h4017);
    sel_prg_s  = bus.addr[15];
    pad1_bit_s = strobe_q ? pad1_buttons[0] : ((cnt1_q < CNT_MAX) ? sr1_q[0] : 1'b1);
    pad2_bit_s = strobe_q ? pad2_buttons[0] : ((cnt2_q < CNT_MAX) ? sr2_q[0] : 1'b1);
  end

  // Next-state for read data, strobe and both controller shift chains
  always_comb begin
    rdata_d  = rdata_q;
    strobe_d = strobe_q;
    sr1_d    = sr1_q;
    sr2_d    = sr2_q;
    cnt1_d   = cnt1_q;
    cnt2_d   = cnt2_q;
    // Strobe high reloads the chains every cycle, including the edge that drops it
    if (strobe_q) begin
      sr1_d  = pad1_buttons;
      sr2_d  = pad2_buttons;
      cnt1_d = {CW{1'b0}};
      cnt2_d = {CW{1'b0}};
    end else begin
      sr1_d  = sr1_q;
      sr2_d  = sr2_q;
    end
    if (bus.rw) begin
      if (sel_ram_s) begin
        rdata_d = ram_rd_s;
      end else if (sel_pad1_s) begin
        rdata_d = {rdata_q[7:1], pad1_bit_s};
        if (!strobe_q) begin
          sr1_d  = {1'b1, sr1_q[PAD_BITS-1:1]};
          cnt1_d = sat_inc(cnt1_q);
        end else begin
          cnt1_d = {CW{1'b0}};
        end
      end else if (sel_pad2_s) begin
        rdata_d = {rdata_q[7:1], pad2_bit_s};
        if (!strobe_q) begin
          sr2_d  = {1'b1, sr2_q[PAD_BITS-1:1]};
          cnt2_d = sat_inc(cnt2_q);
        end else begin
          cnt2_d = {CW{1'b0}};
        end
      end else if (sel_prg_s) begin
        rdata_d = prg_data;
      end else begin
        rdata_d = rdata_q;
      end
    end else begin
      if (sel_pad1_s) begin
        strobe_d = bus.wdata[0];
      end else begin
        strobe_d = strobe_q;
      end
    end
  end

  // Control/data state registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdata_q  <= 8'h00;
      strobe_q <= 1'b0;
      sr1_q    <= {PAD_BITS{1'b0}};
      sr2_q    <= {PAD_BITS{1'b0}};
      cnt1_q   <= CNT_MAX;
      cnt2_q   <= CNT_MAX;
    end else begin
      rdata_q  <= rdata_d;
      strobe_q <= strobe_d;
      sr1_q    <= sr1_d;
      sr2_q    <= sr2_d;
      cnt1_q   <= cnt1_d;
      cnt2_q   <= cnt2_d;
    end
  end

  // Work RAM keeps its contents across reset
  always_ff @(posedge clk) begin
    if (!bus.rw && sel_ram_s) begin
      ram_q[ram_idx_s] <= bus.wdata;
    end
  end

endmodule

// File: tb/tb_nes_cpu_bus_responder.sv
// Randomized bench for nes_cpu_bus_responder checked against a behavioural
// model of the memory map and controller ports.
module tb_nes_cpu_bus_responder;
  logic        clk = 1'b0;
  logic        rst;
  logic [14:0] prg_addr;
  logic [7:0]  prg_data;
  logic [7:0]  pad1, pad2;
  logic [7:0]  prg_seed;

  nes_cpu_bus_responder_if bus();

  nes_cpu_bus_responder #(.RAM_AW(11), .PAD_BITS(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus),
    .prg_addr     (prg_addr),
    .prg_data     (prg_data),
    .pad1_buttons (pad1),
    .pad2_buttons (pad2)
  );

  always #5 clk = ~clk;

  // ROM contents are a function of the address so a wrong prg_addr shows up
  assign prg_data = prg_addr[7:0] ^ {1'b0, prg_addr[14:8]} ^ prg_seed;

  int total = 0;
  int bad   = 0;

  logic [7:0] m_mem [2048];
  logic       m_strobe;
  logic [7:0] m_lat1, m_lat2;
  int         m_idx1, m_idx2;
  logic [7:0] m_rdata;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %02h expected %02h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_rdata  = 8'h00;
    m_strobe = 1'b0;
    m_lat1   = 8'h00;
    m_lat2   = 8'h00;
    m_idx1   = 8;
    m_idx2   = 8;
  endtask

  // Model: a latched button byte plus how many bits have been read out of it
  task automatic model_step(input logic [15:0] a, input logic r, input logic [7:0] wd);
    logic nstrobe;
    logic b;
    nstrobe = m_strobe;
    if (r) begin
      if (a < 16'h2000) begin
        m_rdata = m_mem[a[10:0]];
      end else if (a == 16'h4016) begin
        b = m_strobe ? pad1[0] : ((m_idx1 < 8) ? m_lat1[m_idx1] : 1'b1);
        m_rdata = {m_rdata[7:1], b};
        if (!m_strobe && m_idx1 < 8) m_idx1++;
      end else if (a == 16'h4017) begin
        b = m_strobe ? pad2[0] : ((m_idx2 < 8) ? m_lat2[m_idx2] : 1'b1);
        m_rdata = {m_rdata[7:1], b};
        if (!m_strobe && m_idx2 < 8) m_idx2++;
      end else if (a >= 16'h8000) begin
        m_rdata = a[7:0] ^ {1'b0, a[14:8]} ^ prg_seed;
      end
    end else begin
      if (a < 16'h2000) m_mem[a[10:0]] = wd;
      if (a == 16'h4016) nstrobe = wd[0];
    end
    if (m_strobe) begin
      m_lat1 = pad1;
      m_lat2 = pad2;
      m_idx1 = 0;
      m_idx2 = 0;
    end
    m_strobe = nstrobe;
  endtask

  task automatic bus_cycle(input logic [15:0] a, input logic r, input logic [7:0] wd, input string tag);
    bus.addr  = a;
    bus.rw    = r;
    bus.wdata = wd;
    model_step(a, r, wd);
    @(posedge clk);
    #1;
    chk(tag, bus.rdata, m_rdata);
  endtask

  initial begin
    int exp_seq [10];
    logic [15:0] a;
    logic        r;
    int          kind;
    exp_seq = '{1, 0, 0, 1, 0, 0, 0, 0, 1, 1};

    rst       = 1'b0;
    bus.addr  = 16'h5000;
    bus.rw    = 1'b1;
    bus.wdata = 8'h00;
    pad1      = 8'h00;
    pad2      = 8'h00;
    prg_seed  = 8'h00;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_rdata", bus.rdata, 8'h00);
    rst = 1'b1;

    // RAM mirroring
    bus_cycle(16'h0123, 1'b0, 8'h5A, "ram_wr");
    bus_cycle(16'h0124, 1'b0, 8'h33, "ram_wr");
    bus_cycle(16'h0923, 1'b1, 8'h00, "ram_mirror_0923");
    chk("ram_mirror_0923_const", bus.rdata, 8'h5A);
    bus_cycle(16'h1123, 1'b1, 8'h00, "ram_mirror_1123");
    bus_cycle(16'h1923, 1'b1, 8'h00, "ram_mirror_1923");
    chk("ram_mirror_1923_const", bus.rdata, 8'h5A);
    bus_cycle(16'h0124, 1'b1, 8'h00, "ram_0124");
    chk("ram_0124_const", bus.rdata, 8'h33);

    // Open bus after reset, PRG read, open bus again
    rst = 1'b0;
    #1;
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    bus_cycle(16'h5000, 1'b1, 8'h00, "openbus_after_reset");
    chk("openbus_after_reset_const", bus.rdata, 8'h00);
    prg_seed = 8'hA9 ^ 8'h03;
    bus_cycle(16'h8003, 1'b1, 8'h00, "prg_8003");
    chk("prg_8003_const", bus.rdata, 8'hA9);
    bus_cycle(16'h5000, 1'b1, 8'h00, "openbus_hold");
    chk("openbus_hold_const", bus.rdata, 8'hA9);
    bus_cycle(16'h8003, 1'b0, 8'h11, "prg_write_ignored");

    // Pad 1 serial sequence
    pad1 = 8'h09;
    bus_cycle(16'h4016, 1'b0, 8'h01, "strobe_on");
    bus_cycle(16'h4016, 1'b0, 8'h00, "strobe_off");
    pad1 = 8'hFF;
    for (int i = 0; i < 10; i++) begin
      bus_cycle(16'h4016, 1'b1, 8'h00, "pad1_read");
      chk("pad1_seq_bit0", {7'd0, bus.rdata[0]}, 8'(exp_seq[i]));
    end

    // Strobe held: bit0 follows live button A, no shifting
    bus_cycle(16'h4016, 1'b0, 8'hFF, "strobe_hold_on");
    for (int i = 0; i < 3; i++) begin
      pad1 = pad1 ^ 8'h01;
      bus_cycle(16'h4016, 1'b1, 8'h00, "strobe_live_read");
      chk("strobe_live_bit0", {7'd0, bus.rdata[0]}, {7'd0, pad1[0]});
    end
    bus_cycle(16'h4016, 1'b0, 8'h00, "strobe_hold_off");
    pad1 = 8'h00;
    for (int i = 0; i < 9; i++) bus_cycle(16'h4016, 1'b1, 8'h00, "pad1_after_hold");

    // Pad 2 with interleaved pad 1 reads
    pad2 = 8'h80;
    bus_cycle(16'h4016, 1'b0, 8'h01, "strobe2_on");
    bus_cycle(16'h4016, 1'b0, 8'h00, "strobe2_off");
    pad2 = 8'h00;
    for (int i = 0; i < 8; i++) begin
      bus_cycle(16'h4017, 1'b1, 8'h00, "pad2_read");
      chk("pad2_seq_bit0", {7'd0, bus.rdata[0]}, (i == 7) ? 8'h01 : 8'h00);
      bus_cycle(16'h4016, 1'b1, 8'h00, "pad1_interleave");
    end
    bus_cycle(16'h4017, 1'b0, 8'h01, "wr_4017_ignored");
    bus_cycle(16'h4017, 1'b1, 8'h00, "pad2_after_ignored_write");

    // Asynchronous reset during a mid-sequence controller read
    pad1 = 8'h5A;
    bus_cycle(16'h4016, 1'b0, 8'h01, "strobe3_on");
    bus_cycle(16'h4016, 1'b0, 8'h00, "strobe3_off");
    bus_cycle(16'h4016, 1'b1, 8'h00, "pad1_pre_reset");
    bus_cycle(16'h4016, 1'b1, 8'h00, "pad1_pre_reset");
    bus.addr = 16'h4016;
    bus.rw   = 1'b1;
    #2;
    rst = 1'b0;
    #1;
    chk("rst_async", bus.rdata, 8'h00);
    model_reset();
    @(posedge clk);
    #1;
    chk("rst_held", bus.rdata, 8'h00);
    rst = 1'b1;
    bus_cycle(16'h4016, 1'b1, 8'h00, "pad1_after_reset");
    chk("pad1_after_reset_const", bus.rdata, 8'h01);
    bus_cycle(16'h0123, 1'b1, 8'h00, "ram_survives_reset");
    chk("ram_survives_reset_const", bus.rdata, 8'h5A);

    // Fill RAM so every location has a known value, then random traffic
    for (int i = 0; i < 2048; i++) bus_cycle(16'(i), 1'b0, 8'($urandom), "ram_fill");
    for (int n = 0; n < 4000; n++) begin
      kind = $urandom_range(0, 9);
      r = 1'b1;
      if ($urandom_range(0, 7) == 0) pad1 = 8'($urandom);
      if ($urandom_range(0, 7) == 0) pad2 = 8'($urandom);
      prg_seed = 8'($urandom);
      case (kind)
        0, 1, 2, 3: begin a = 16'($urandom_range(0, 16'h1FFF)); r = 1'($urandom); end
        4:          begin a = 16'h4016; r = ($urandom_range(0, 5) != 0); end
        5:          begin a = 16'h4017; r = ($urandom_range(0, 5) != 0); end
        6, 7:       begin a = 16'($urandom_range(16'h8000, 16'hFFFF)); r = ($urandom_range(0, 3) != 0); end
        8:          begin
                      a = 16'($urandom_range(16'h2000, 16'h7FFF));
                      if (a == 16'h4016 || a == 16'h4017) a = 16'h5000;
                      r = 1'($urandom);
                    end
        default:    begin a = 16'h4016; r = ($urandom_range(0, 3) != 0); end
      endcase
      bus_cycle(a, r, 8'($urandom), "random");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/nes_cpu_bus_responder.md
Name: nes_cpu_bus_responder

Overview:
- Slave side of the CPU data/address bus; answers every CPU access.
- Contains the 2 KB internal work RAM, mirrored across $0000-$1FFF.
- Contains the two serial controller ports at $4016/$4017.
- Forwards $8000-$FFFF reads to external PRG-ROM; every other address returns open-bus data.
- Sits between the cpu module (addr, d_out, d_in) and the RAM, ROM and joypad hardware.

Parameters:
- RAM_AW, 11, work-RAM address width (2^RAM_AW bytes; mirrored to fill $0000-$1FFF).
- PAD_BITS, 8, buttons per controller shift chain.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-low reset.
- addr  input  16  CPU address bus.
- rw  input  1  1 = CPU read, 0 = CPU write; sampled on the rising edge of clk.
- wdata  input  8  CPU write data (CPU d_out).
- rdata  output  8  read data to CPU (CPU d_in), registered.
- prg_addr  output  15  PRG-ROM address; combinational, equal to addr[14:0].
- prg_data  input  8  PRG-ROM data; valid combinationally for prg_addr.
- pad1_buttons  input  PAD_BITS  live controller 1 buttons, active-high. Bit order: 0=A, 1=B, 2=Select, 3=Start, 4=Up, 5=Down, 6=Left, 7=Right.
- pad2_buttons  input  PAD_BITS  live controller 2 buttons, same order.

Behaviour:
- Decode on addr:
  - $0000-$1FFF: RAM at addr[RAM_AW-1:0].
  - $4016: pad 1 / strobe.
  - $4017: pad 2.
  - $8000-$FFFF: PRG.
  - All else: unmapped.
- Read latency is 1 cycle. For an access presented in cycle N with rw=1, rdata holds the data from the rising edge that ends cycle N until the next read edge. rdata does not change on write cycles.
- RAM read: synchronous; returns ram[index] as stored before the edge.
- RAM write: at an edge with rw=0, ram[index] <= wdata. A read of the same location in the next cycle returns the new value.
- PRG read: rdata <= prg_data. Writes to $8000-$FFFF are ignored.
- Open bus: open_bus register tracks rdata (it is rdata). Unmapped reads, and writes anywhere outside RAM/$4016, leave rdata unchanged.
- $4016 write: strobe <= wdata[0]. Other bits are ignored. A write to $4017 is ignored.
- Controller shift registers sr1 and sr2 (PAD_BITS wide), plus counters cnt1 and cnt2 (0..PAD_BITS, saturating):
  - While strobe=1, every cycle: sr1 <= pad1_buttons, sr2 <= pad2_buttons, cnt1 = cnt2 = 0.
  - The value captured in the last cycle with strobe=1 is the value held after strobe falls.
  - $4016 read: rdata <= {rdata[7:1], s1}.
    - s1 = pad1_buttons[0] if strobe=1.
    - Else s1 = sr1[0] if cnt1<PAD_BITS.
    - Else s1 = 1.
  - On that same edge, if strobe=0: sr1 <= {1'b1, sr1[PAD_BITS-1:1]} and cnt1 <= min(cnt1+1, PAD_BITS).
  - $4017 read: identical, using pad2/sr2/cnt2.
  - Reads with strobe=1 do not shift.
- Simultaneous events:
  - A $4016 write that clears strobe takes effect at that edge. Its capture uses the pad value present in the last strobe=1 cycle, i.e. sr holds the value captured one edge earlier.
  - Pad input changes while strobe=0 have no effect.
- Reset (rst=0, asynchronous):
  - rdata=0, strobe=0, sr1=sr2=0, cnt1=cnt2=PAD_BITS.
  - RAM contents are not reset.
  - Reset asserted mid-read cancels the shift.
- After reset release, the first edge behaves as normal. A read of $4016 before any strobe returns bit0=1.
- The block contains no FSM beyond the strobe/counter state. The entire block is single-clock.

Test Plan:
- Write $0123=$5A, then read $0923, $1123 and $1923 -> each rdata=$5A one cycle after its address; a read of $0124 still returns its own stored value.
- Apply reset, then read $5000 -> rdata=$00. Read $8003 with prg_data=$A9 -> rdata=$A9. Read $5000 again -> rdata stays $A9 (open bus).
- pad1_buttons=$09 (A+Start); write $4016=$01, then $4016=$00; change pad1 to $FF; read $4016 ten times -> bit0 sequence 1,0,0,1,0,0,0,0,1,1. Bits 7:1 equal the previous rdata[7:1].
- Strobe held at 1 with pad1 toggling bit0 each cycle; read $4016 three times -> bit0 follows live pad1[0] and cnt1 stays 0. After strobe=0 the shift starts from the last captured value.
- pad2_buttons=$80 latched; read $4017 eight times -> seven 0s then 1. Interleaved $4016 reads do not advance cnt2.
- Assert rst during a $4016 read mid-sequence -> rdata=0 immediately (asynchronous); after release a $4016 read returns bit0=1; RAM location written before reset still reads back its old value.
